// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin arbiter and sequencer that shares one 4:1 WIDTH-bit
//            data mux among four requesters. Each granted requester gets one
//            registered beat on a valid/ready port, followed by a one-cycle
//            ack pulse. An optional stall timeout drops a beat that the
//            consumer never accepts.
// Ports    : clk          - rising-edge clock
//            rst          - synchronous reset, active-high
//            req[3:0]     - per-requester request, held until ack
//            in0..in3     - requester data
//            out_ready    - consumer ready
//            out_valid    - out_data holds a beat
//            out_data     - registered mux output
//            sel[1:0]     - current / last granted requester (mux control)
//            ack[3:0]     - one-hot pulse to the requester whose beat was taken
//            timeout_err  - one-cycle pulse when a beat is dropped
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic             timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // The beat is dropped at the edge that closes the TIMEOUT-th stalled cycle;
  // the counter starts at 0 on the grant, so it reads TIMEOUT-1 at that edge.
  localparam bit         TO_EN   = (TIMEOUT > 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic [3:0]       ack_nxt;
  logic             err_nxt;
  logic [7:0]       cnt, cnt_nxt;

  logic [3:0]       eff_req;
  logic [3:0]       rot;
  logic [1:0]       off;
  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_data;

  // The requester being acked this cycle still has req high; masking it
  // keeps it from being regranted before it has a chance to drop req.
  assign eff_req = req & ~ack;

  // Rotate so that bit 0 is the requester at ptr, then pick the first set bit.
  always_comb begin
    case (ptr)
      2'd0:    rot = eff_req;
      2'd1:    rot = {eff_req[0],   eff_req[3:1]};
      2'd2:    rot = {eff_req[1:0], eff_req[3:2]};
      default: rot = {eff_req[2:0], eff_req[3]};
    endcase
  end

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign grant = ptr + off;   // 2-bit wrap gives the mod-4 index

  always_comb begin
    case (grant)
      2'd0:    grant_data = in0;
      2'd1:    grant_data = in1;
      2'd2:    grant_data = in2;
      default: grant_data = in3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    cnt_nxt   = cnt;
    ack_nxt   = 4'b0000;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|eff_req) begin
          sel_nxt   = grant;
          data_nxt  = grant_data;
          valid_nxt = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // Handshake is tested first so it wins over a coincident timeout.
        if (out_ready) begin
          valid_nxt = 1'b0;
          ack_nxt   = 4'b0001 << sel;
          ptr_nxt   = sel + 2'd1;
          state_nxt = ST_IDLE;
        end else if (TO_EN) begin
          if (cnt == TO_LAST) begin
            valid_nxt = 1'b0;
            err_nxt   = 1'b1;
            ptr_nxt   = sel + 2'd1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= 2'd0;
      sel         <= 2'd0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      ack         <= 4'b0000;
      timeout_err <= 1'b0;
      cnt         <= 8'd0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      sel         <= sel_nxt;
      out_valid   <= valid_nxt;
      out_data    <= data_nxt;
      ack         <= ack_nxt;
      timeout_err <= err_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 WIDTH-bit data mux among four requesters. Each granted requester gets one registered beat on a valid/ready output port, then an ack pulse. The block drives the mux select (sel), so any downstream consumer sees one source at a time with a fairness guarantee. An optional timeout drops a beat when the consumer stalls.

Parameters:
WIDTH, 4, data width of each input and of out_data.
TIMEOUT, 0, number of consecutive stalled SEND cycles before the beat is dropped. 0 disables the timeout. Legal range 0..255.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
req  input  4  per-requester request. Must be held high until ack.
in0  input  WIDTH  requester 0 data.
in1  input  WIDTH  requester 1 data.
in2  input  WIDTH  requester 2 data.
in3  input  WIDTH  requester 3 data.
out_ready  input  1  consumer ready.
out_valid  output  1  out_data holds a beat.
out_data  output  WIDTH  registered mux output.
sel  output  2  index of the current or last granted requester (mux control).
ack  output  4  one-hot, one-cycle pulse to the requester whose beat was accepted.
timeout_err  output  1  one-cycle pulse when a beat is dropped.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0, ack=0, timeout_err=0, stall counter=0.
  - Reset overrides all other events.
  - Reset during SEND abandons the beat: no ack and no timeout_err are issued.
- Masking: eff_req = req & ~ack. The requester being acked this cycle cannot be regranted in the same cycle.
- IDLE state:
  - If eff_req is nonzero, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the edge: sel<=g, out_data<=in[g], out_valid<=1, counter<=0, state<=SEND.
  - If eff_req is zero, hold all outputs; out_valid stays 0.
- SEND state:
  - out_valid=1. out_data and sel are stable regardless of changes on req or inX.
  - Handshake: out_valid & out_ready at an edge. Then out_valid<=0, ack<=onehot(sel) for the next cycle only, ptr<=(sel+1) mod 4, state<=IDLE.
  - Stall (out_ready low) with TIMEOUT>0: counter increments each stalled cycle. At the edge closing the TIMEOUT-th consecutive stalled cycle:
    - out_valid<=0, timeout_err<=1 for one cycle;
    - no ack; ptr<=(sel+1) mod 4; state<=IDLE.
    - The requester keeps req high and retries later.
  - If handshake and timeout coincide at the same edge, the handshake wins (ack, no err).
- Latency and throughput:
  - req→out_valid: 1 cycle.
  - Handshake edge→ack visible: 1 cycle.
  - Maximum rate: 1 beat per 2 cycles (SEND→IDLE→SEND).
- Fairness: a continuously requesting source waits at most 3 other grants.
- ack and timeout_err are registered, never combinational from out_ready.
- ptr wraps 3→0.

Test Plan:
1. Reset: rst=1 for 2 edges with all req high → out_valid=0, out_data=0, sel=0, ack=0, timeout_err=0 throughout.
2. Single request: req=4'b0100, in2=4'b1111, out_ready=1 → next cycle out_valid=1, sel=2, out_data=1111. Following cycle out_valid=0, ack=4'b0100. No regrant in the ack cycle.
3. All requesting: req=4'b1111, in0=0101, in1=0000, in2=1111, in3=0011, out_ready=1 → out_data sequence 0101, 0000, 1111, 0011, 0101. sel sequence 0, 1, 2, 3, 0. One beat every 2 cycles, with ack pulses matching each beat.
4. Backpressure: grant requester 1 with out_ready=0 for 5 cycles and TIMEOUT=0 → out_valid and out_data held 6 cycles. Changing in1 mid-stall does not change out_data. ack=4'b0010 only after ready rises.
5. Timeout: TIMEOUT=4, req=4'b0011, out_ready=0 → out_valid high exactly 4 cycles, then timeout_err pulses once with no ack. Next grant has sel=1. Raising out_ready on the 4th stalled cycle instead yields an ack with no err.
6. Reset mid-SEND: assert rst while out_valid=1 on sel=2 → next cycle all outputs 0 with no ack. After release, req=4'b1100 grants sel=2 first (ptr=0).
